vram_port_scheduler: RTL and testbench



---
 rtl/vram_pkg.sv | 27 ++
 rtl/vram_video_prefetch.sv | 77 +++++++
 rtl/vram_port_scheduler.sv | 165 ++++++++++++++++
 tb/tb_vram_port_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared geometry, issue tags and host FSM encoding for the text VRAM scheduler.
package vram_pkg;

  localparam int H_VISIBLE     = 640;
  localparam int V_VISIBLE     = 480;
  localparam int H_TOTAL_DEF   = 800;
  localparam int V_TOTAL_DEF   = 525;
  localparam int CELL_W        = 8;
  localparam int CELL_H        = 16;
  localparam int WORDS_ROW_DEF = 20;
  localparam int VRAM_WORDS_DEF = 600;

  // Pixel phase inside a 32-pixel word span at which the next word is fetched.
  localparam logic [4:0] INLINE_PHASE = 5'd24;

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_HOST} issue_tag_e;
  typedef enum logic [1:0] {HST_IDLE, HST_GRANT, HST_ACK} host_state_e;
  typedef enum logic [1:0] {HK_VRAM, HK_CTRL, HK_NONE} host_kind_e;

  // row*20 as shift-add; exact for rows 0..29 in 10 bits.
  function automatic logic [9:0] row_base(input logic [4:0] row);
    logic [9:0] r;
    r = {5'd0, row};
    return (r << 4) + (r << 2);
  endfunction

endpackage

// File: rtl/vram_video_prefetch.sv
// Video fetch slot timing/address from the raster position, plus the
// next_word/cur_word double buffer and the per-cell character byte mux.
module vram_video_prefetch
  import vram_pkg::*;
#(
  parameter int H_TOTAL       = H_TOTAL_DEF,
  parameter int V_TOTAL       = V_TOTAL_DEF,
  parameter int WORDS_PER_ROW = WORDS_ROW_DEF
) (
  input  logic        pixel_clk,
  input  logic        arstn,
  input  logic [9:0]  draw_x_i,
  input  logic [9:0]  draw_y_i,
  input  logic        data_vld_i,
  input  logic [31:0] data_i,
  output logic        slot_o,
  output logic [9:0]  slot_addr_o,
  output logic [7:0]  char_byte_o
);

  localparam logic [9:0] X_LAST         = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST         = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_LINE_FETCH   = 10'(H_TOTAL - CELL_W);
  localparam logic [9:0] Y_VIS          = 10'(V_VISIBLE);
  localparam logic [4:0] LAST_FETCH_COL = 5'(WORDS_PER_ROW - 1);

  logic [9:0]  ny;
  logic        inline_hit;
  logic        line_hit;
  logic [31:0] next_word_q, next_word_d;
  logic [31:0] cur_word_q, cur_word_d;

  always_comb begin
    ny          = (draw_y_i == Y_LAST) ? 10'd0 : draw_y_i + 10'd1;
    inline_hit  = (draw_x_i[4:0] == INLINE_PHASE) && (draw_x_i[9:5] < LAST_FETCH_COL) &&
                  (draw_y_i < Y_VIS);
    line_hit    = (draw_x_i == X_LINE_FETCH) && (ny < Y_VIS);
    slot_o      = inline_hit || line_hit;
    slot_addr_o = '0;
    if (line_hit) begin
      slot_addr_o = row_base(ny[8:4]);
    end else if (inline_hit) begin
      slot_addr_o = row_base(draw_y_i[8:4]) + {5'd0, draw_x_i[9:5]} + 10'd1;
    end
  end

  always_comb begin
    next_word_d = data_vld_i ? data_i : next_word_q;
    cur_word_d  = cur_word_q;
    if ((draw_x_i[4:0] == 5'd31) || (draw_x_i == X_LAST)) begin
      cur_word_d = next_word_q;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      next_word_q <= '0;
      cur_word_q  <= '0;
    end else begin
      next_word_q <= next_word_d;
      cur_word_q  <= cur_word_d;
    end
  end

  // Byte 0 is the leftmost cell of the word.
  always_comb begin
    char_byte_o = '0;
    case (draw_x_i[4:3])
      2'd0: char_byte_o = cur_word_q[7:0];
      2'd1: char_byte_o = cur_word_q[15:8];
      2'd2: char_byte_o = cur_word_q[23:16];
      2'd3: char_byte_o = cur_word_q[31:24];
      default: char_byte_o = '0;
    endcase
  end

endmodule

// File: rtl/vram_port_scheduler.sv
// Arbitrates the single-port text VRAM between video prefetch (absolute priority)
// and the host word port; holds the control register at word VRAM_WORDS.
module vram_port_scheduler
  import vram_pkg::*;
#(
  parameter int H_TOTAL       = H_TOTAL_DEF,
  parameter int V_TOTAL       = V_TOTAL_DEF,
  parameter int VRAM_WORDS    = VRAM_WORDS_DEF,
  parameter int WORDS_PER_ROW = WORDS_ROW_DEF
) (
  input  logic        pixel_clk,
  input  logic        arstn,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [9:0]  host_addr,
  input  logic [3:0]  host_be,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        vram_en,
  output logic [3:0]  vram_we,
  output logic [9:0]  vram_addr,
  output logic [31:0] vram_wdata,
  input  logic [31:0] vram_rdata,
  output logic [7:0]  char_byte,
  output logic [31:0] ctrl_reg
);

  localparam logic [9:0] CTRL_ADDR = 10'(VRAM_WORDS);

  host_state_e state_q, state_d;
  issue_tag_e  tag_q, tag_d, tag_rd_q;
  host_kind_e  kind_q, kind_d, kind_in;
  logic        hwe_q, hwe_d;
  logic [3:0]  hbe_q, hbe_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        vram_en_q, vram_en_d;
  logic [3:0]  vram_we_q, vram_we_d;
  logic [9:0]  vram_addr_q, vram_addr_d;
  logic [31:0] vram_wdata_q, vram_wdata_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        vid_slot;
  logic [9:0]  vid_addr;
  logic        grant;

  vram_video_prefetch #(
    .H_TOTAL      (H_TOTAL),
    .V_TOTAL      (V_TOTAL),
    .WORDS_PER_ROW(WORDS_PER_ROW)
  ) u_prefetch (
    .pixel_clk  (pixel_clk),
    .arstn      (arstn),
    .draw_x_i   (drawX),
    .draw_y_i   (drawY),
    .data_vld_i (tag_rd_q == TAG_VID),
    .data_i     (vram_rdata),
    .slot_o     (vid_slot),
    .slot_addr_o(vid_addr),
    .char_byte_o(char_byte)
  );

  always_comb begin
    kind_in = HK_NONE;
    if (host_addr < CTRL_ADDR)       kind_in = HK_VRAM;
    else if (host_addr == CTRL_ADDR) kind_in = HK_CTRL;

    // IDLE already implies nothing in flight and host_ack low.
    grant = host_req && !vid_slot && (state_q == HST_IDLE);

    state_d = state_q;
    case (state_q)
      HST_IDLE:  if (grant) state_d = HST_GRANT;
      HST_GRANT: state_d = HST_ACK;
      HST_ACK:   state_d = HST_IDLE;
      default:   state_d = HST_IDLE;
    endcase

    kind_d   = kind_q;
    hwe_d    = hwe_q;
    hbe_d    = hbe_q;
    hwdata_d = hwdata_q;
    if (grant) begin
      kind_d   = kind_in;
      hwe_d    = host_we;
      hbe_d    = host_be;
      hwdata_d = host_wdata;
    end

    vram_en_d    = 1'b0;
    vram_we_d    = '0;
    vram_addr_d  = '0;
    vram_wdata_d = '0;
    tag_d        = TAG_NONE;
    if (vid_slot) begin
      vram_en_d   = 1'b1;
      vram_addr_d = vid_addr;
      tag_d       = TAG_VID;
    end else if (grant && (kind_in == HK_VRAM)) begin
      vram_en_d    = 1'b1;
      vram_we_d    = host_we ? host_be : 4'b0000;
      vram_addr_d  = host_addr;
      vram_wdata_d = host_wdata;
      tag_d        = TAG_HOST;
    end

    ctrl_d = ctrl_q;
    if ((state_q == HST_GRANT) && hwe_q && (kind_q == HK_CTRL)) begin
      for (int b = 0; b < 4; b++) begin
        if (hbe_q[b]) ctrl_d[b*8 +: 8] = hwdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state_q      <= HST_IDLE;
      tag_q        <= TAG_NONE;
      tag_rd_q     <= TAG_NONE;
      kind_q       <= HK_NONE;
      hwe_q        <= 1'b0;
      hbe_q        <= '0;
      hwdata_q     <= '0;
      vram_en_q    <= 1'b0;
      vram_we_q    <= '0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      ctrl_q       <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      tag_rd_q     <= tag_q;
      kind_q       <= kind_d;
      hwe_q        <= hwe_d;
      hbe_q        <= hbe_d;
      hwdata_q     <= hwdata_d;
      vram_en_q    <= vram_en_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      ctrl_q       <= ctrl_d;
    end
  end

  // Read data for the host arrives in the ACK cycle, one cycle after its issue.
  always_comb begin
    host_rdata = '0;
    if ((state_q == HST_ACK) && !hwe_q) begin
      case (kind_q)
        HK_VRAM: host_rdata = vram_rdata;
        HK_CTRL: host_rdata = ctrl_q;
        default: host_rdata = '0;
      endcase
    end
  end

  assign host_ack   = (state_q == HST_ACK);
  assign vram_en    = vram_en_q;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
  assign ctrl_reg   = ctrl_q;

endmodule

// File: tb/tb_vram_port_scheduler.sv
// Bench for vram_port_scheduler: VRAM model, host word-access model, raster char check.
module tb_vram_port_scheduler;

  logic        pixel_clk = 1'b0;
  logic        arstn;
  logic [9:0]  drawX, drawY;
  logic        host_req, host_we;
  logic [9:0]  host_addr;
  logic [3:0]  host_be;
  logic [31:0] host_wdata, host_rdata;
  logic        host_ack;
  logic        vram_en;
  logic [3:0]  vram_we;
  logic [9:0]  vram_addr;
  logic [31:0] vram_wdata;
  logic [31:0] vram_rdata = '0;
  logic [7:0]  char_byte;
  logic [31:0] ctrl_reg;

  always #5 pixel_clk = ~pixel_clk;

  vram_port_scheduler dut (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .drawX     (drawX),
    .drawY     (drawY),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_be   (host_be),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_ack  (host_ack),
    .vram_en   (vram_en),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .char_byte (char_byte),
    .ctrl_reg  (ctrl_reg)
  );

  // Synchronous single-port RAM, one cycle read latency.
  logic [31:0] vmem [600] = '{default: '0};
  always @(posedge pixel_clk) begin
    if (vram_en && (vram_addr < 10'd600)) begin
      for (int b = 0; b < 4; b++) begin
        if (vram_we[b]) vmem[vram_addr][b*8 +: 8] <= vram_wdata[b*8 +: 8];
      end
      vram_rdata <= vmem[vram_addr];
    end
  end

  // Reference state: what the host should observe.
  logic [31:0] shadow [600];
  logic [31:0] shadow_ctrl;
  int total = 0;
  int bad   = 0;
  bit raster_run = 1'b0;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_ctrl;
    int          exp_ens;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge pixel_clk);
    if (raster_run) begin
      if (drawX == 10'd799) begin
        drawX = 10'd0;
        drawY = (drawY == 10'd524) ? 10'd0 : drawY + 10'd1;
      end else begin
        drawX = drawX + 10'd1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic model_access(input logic we, input logic [9:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] exp_rd);
    exp_rd = '0;
    if (we) begin
      if (addr < 10'd600) shadow[addr] = merge(shadow[addr], wd, be);
      else if (addr == 10'd600) shadow_ctrl = merge(shadow_ctrl, wd, be);
    end else begin
      if (addr < 10'd600) exp_rd = shadow[addr];
      else if (addr == 10'd600) exp_rd = shadow_ctrl;
    end
  endtask

  task automatic host_access(input logic we, input logic [9:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat,
                             output int ens, output bit ok);
    host_we = we; host_addr = addr; host_be = be; host_wdata = wd; host_req = 1'b1;
    rd = '0; lat = 0; ens = 0; ok = 1'b0;
    while (!ok && lat < 10) begin
      tick();
      lat++;
      if (vram_en) ens++;
      if (host_ack) begin
        ok = 1'b1;
        rd = host_rdata;
      end
    end
    host_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, exp;
    int lat, ens, linebad, sel;
    bit ok, force_vid;
    logic we;
    logic [9:0] addr;

    for (int i = 0; i < 600; i++) shadow[i] = '0;
    shadow_ctrl = '0;
    arstn = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 10'd5;
    host_be = 4'hF; host_wdata = '0; drawX = 10'd24; drawY = 10'd16;

    // Reset held with a pending request and a video slot position.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_ack_en", {host_ack, vram_en}, 2'b00);
    end
    check("rst_char", char_byte, 8'h00);
    check("rst_ctrl", ctrl_reg, 32'h0);
    check("rst_rdata", host_rdata, 32'h0);
    host_req = 1'b0; drawX = 10'd100; drawY = 10'd0;
    arstn = 1'b1;
    tick();

    // Reset in the middle of a host access abandons it.
    host_we = 1'b0; host_addr = 10'd5; host_req = 1'b1;
    tick();
    check("midrst_granted", {vram_en, vram_addr}, {1'b1, 10'd5});
    arstn = 1'b0; host_req = 1'b0;
    tick();
    check("midrst_clear", {host_ack, vram_en}, 2'b00);
    arstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_ack", host_ack, 1'b0);
    end

    // Directed host accesses with the raster parked outside any video slot.
    vecs[0]  = '{1'b1, 10'd5,   4'hF,    32'hA5A5_1234, 32'h0,          32'h0,          1};
    vecs[1]  = '{1'b0, 10'd5,   4'h0,    32'h0,         32'hA5A5_1234,  32'h0,          1};
    vecs[2]  = '{1'b1, 10'd600, 4'hF,    32'hFFFF_FFFF, 32'h0,          32'hFFFF_FFFF,  0};
    vecs[3]  = '{1'b1, 10'd600, 4'b0011, 32'h001F_6000, 32'h0,          32'hFFFF_6000,  0};
    vecs[4]  = '{1'b0, 10'd600, 4'h0,    32'h0,         32'hFFFF_6000,  32'hFFFF_6000,  0};
    vecs[5]  = '{1'b0, 10'd700, 4'h0,    32'h0,         32'h0,          32'hFFFF_6000,  0};
    vecs[6]  = '{1'b1, 10'd700, 4'hF,    32'hDEAD_BEEF, 32'h0,          32'hFFFF_6000,  0};
    vecs[7]  = '{1'b0, 10'd5,   4'h0,    32'h0,         32'hA5A5_1234,  32'hFFFF_6000,  1};
    vecs[8]  = '{1'b1, 10'd5,   4'b0100, 32'h0077_0000, 32'h0,          32'hFFFF_6000,  1};
    vecs[9]  = '{1'b0, 10'd5,   4'h0,    32'h0,         32'hA577_1234,  32'hFFFF_6000,  1};
    vecs[10] = '{1'b1, 10'd599, 4'b0001, 32'h1234_5678, 32'h0,          32'hFFFF_6000,  1};
    vecs[11] = '{1'b0, 10'd599, 4'h0,    32'h0,         32'h0000_0078,  32'hFFFF_6000,  1};
    vecs[12] = '{1'b1, 10'd601, 4'hF,    32'h1111_1111, 32'h0,          32'hFFFF_6000,  0};
    vecs[13] = '{1'b0, 10'd601, 4'h0,    32'h0,         32'h0,          32'hFFFF_6000,  0};
    for (int i = 0; i < 14; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, exp);
      host_access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, rd, lat, ens, ok);
      check($sformatf("vec%0d_ack", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_ctrl", i), ctrl_reg, vecs[i].exp_ctrl);
      check($sformatf("vec%0d_vram_cycles", i), 32'(ens), 32'(vecs[i].exp_ens));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      tick();
    end

    // Video slot at drawX=24 wins; the host goes one cycle later.
    drawY = 10'd16; drawX = 10'd24;
    host_we = 1'b0; host_addr = 10'd5; host_req = 1'b1;
    model_access(1'b0, 10'd5, 4'h0, 32'h0, exp);
    tick();
    check("prio_vid_issue", {vram_en, vram_we, vram_addr}, {1'b1, 4'h0, 10'd21});
    check("prio_no_ack_early", host_ack, 1'b0);
    drawX = 10'd25;
    tick();
    check("prio_host_issue", {vram_en, vram_addr}, {1'b1, 10'd5});
    check("prio_no_ack_yet", host_ack, 1'b0);
    drawX = 10'd26;
    tick();
    check("prio_ack", host_ack, 1'b1);
    check("prio_rdata", host_rdata, exp);
    host_req = 1'b0; drawX = 10'd27;
    tick();
    check("prio_ack_one_cycle", host_ack, 1'b0);

    // Line prefetch of row 0 on the last line and the resulting char bytes.
    drawX = 10'd100; drawY = 10'd0;
    model_access(1'b1, 10'd0, 4'hF, 32'h4443_4241, exp);
    host_access(1'b1, 10'd0, 4'hF, 32'h4443_4241, rd, lat, ens, ok);
    check("t5_wr_ack", 32'(ok), 32'd1);
    tick();
    drawY = 10'd524; drawX = 10'd792;
    tick();
    check("t5_prefetch", {vram_en, vram_we, vram_addr}, {1'b1, 4'h0, 10'd0});
    for (int x = 793; x < 800; x++) begin
      drawX = 10'(x);
      tick();
    end
    drawY = 10'd0; drawX = 10'd0; #1;
    check("t5_char_x0", char_byte, 8'h41);
    tick(); drawX = 10'd8; #1;
    check("t5_char_x8", char_byte, 8'h42);
    tick(); drawX = 10'd24; #1;
    check("t5_char_x24", char_byte, 8'h44);
    tick();

    // Random host traffic against the free-running raster.
    drawX = 10'($urandom_range(0, 799)); drawY = 10'($urandom_range(0, 524));
    raster_run = 1'b1;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      if (sel < 7)       addr = 10'($urandom_range(0, 599));
      else if (sel == 7) addr = 10'd600;
      else               addr = 10'($urandom_range(601, 1023));
      force_vid = ($urandom_range(0, 3) == 0);
      if (force_vid) begin
        drawX = 10'(($urandom_range(0, 18) << 5) + 24);
        drawY = 10'($urandom_range(0, 479));
      end
      host_be = 4'($urandom_range(0, 15));
      host_wdata = $urandom;
      model_access(we, addr, host_be, host_wdata, exp);
      host_access(we, addr, host_be, host_wdata, rd, lat, ens, ok);
      check("rand_ack", 32'(ok), 32'd1);
      check("rand_rdata", rd, exp);
      check("rand_ctrl", ctrl_reg, shadow_ctrl);
      if (force_vid) check("rand_deferred_latency", 32'(lat), 32'd3);
      else check("rand_latency_bound", 32'(lat >= 2 && lat <= 3), 32'd1);
      repeat ($urandom_range(1, 3)) tick();
    end
    raster_run = 1'b0;

    // Fill rows 0..2 and scan the raster, comparing every cell's byte.
    drawX = 10'd100; drawY = 10'd0;
    for (int i = 0; i < 60; i++) begin
      host_wdata = $urandom;
      model_access(1'b1, 10'(i), 4'hF, host_wdata, exp);
      host_access(1'b1, 10'(i), 4'hF, host_wdata, rd, lat, ens, ok);
      check("fill_ack", 32'(ok), 32'd1);
      tick();
    end
    drawY = 10'd522; drawX = 10'd0; linebad = 0;
    raster_run = 1'b1;
    for (int c = 0; c < 37 * 800; c++) begin
      tick();
      if (drawY < 10'd480 && drawX < 10'd640 && drawX[2:0] == 3'd0) begin
        exp = shadow[(int'(drawY) / 16) * 20 + int'(drawX) / 32];
        if (char_byte !== exp[((int'(drawX) / 8) % 4) * 8 +: 8]) linebad++;
      end
      if (drawY < 10'd480 && drawX == 10'd640) begin
        check($sformatf("char_line%0d_bad_cells", drawY), 32'(linebad), 32'd0);
        linebad = 0;
      end
    end
    raster_run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
